// File: rtl/hazard_scoreboard_pkg.sv
// Shared WISC decode constants and the scoreboard entry layout.
package hazard_scoreboard_pkg;

    // Opcodes, instr[15:11]
    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_SIIC  = 5'b00010;
    localparam logic [4:0] OP_RTI   = 5'b00011;
    localparam logic [4:0] OP_J     = 5'b00100;
    localparam logic [4:0] OP_JR    = 5'b00101;
    localparam logic [4:0] OP_JAL   = 5'b00110;
    localparam logic [4:0] OP_JALR  = 5'b00111;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_ANDNI = 5'b01011;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_BNEZ  = 5'b01101;
    localparam logic [4:0] OP_BLTZ  = 5'b01110;
    localparam logic [4:0] OP_BGEZ  = 5'b01111;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_SLBI  = 5'b10010;
    localparam logic [4:0] OP_STU   = 5'b10011;
    localparam logic [4:0] OP_ROLI  = 5'b10100;
    localparam logic [4:0] OP_SLLI  = 5'b10101;
    localparam logic [4:0] OP_RORI  = 5'b10110;
    localparam logic [4:0] OP_SRLI  = 5'b10111;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_BTR   = 5'b11001;
    localparam logic [4:0] OP_SHIFT = 5'b11010;
    localparam logic [4:0] OP_ARITH = 5'b11011;
    localparam logic [4:0] OP_SEQ   = 5'b11100;
    localparam logic [4:0] OP_SLT   = 5'b11101;
    localparam logic [4:0] OP_SLE   = 5'b11110;
    localparam logic [4:0] OP_SCO   = 5'b11111;

    // Instruction field positions
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 11;
    localparam int RS_HI  = 10;
    localparam int RS_LO  = 8;
    localparam int RT_HI  = 7;
    localparam int RT_LO  = 5;

    // Register index storage width; wide enough for any supported REG_W
    localparam int SB_REG_W = 8;

    typedef struct packed {
        logic                v;
        logic [SB_REG_W-1:0] rd;
        logic                ld;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_reg_read_decode.sv
// Opcode -> number of register-file reads and which source fields are used.
module reg_read_decode
    import hazard_scoreboard_pkg::*;
(
    input  logic [4:0] opcode,
    output logic [1:0] reg_reads,
    output logic       rs_used,
    output logic       rt_used
);

    // Read count table; anything not listed reads nothing
    always_comb begin
        reg_reads = 2'd0;
        case (opcode)
            OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI,
            OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI,
            OP_LD, OP_SLBI, OP_JR, OP_JALR,
            OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ,
            OP_BTR:                                 reg_reads = 2'd1;
            OP_ST, OP_STU, OP_SHIFT, OP_ARITH,
            OP_SEQ, OP_SLT, OP_SLE, OP_SCO:         reg_reads = 2'd2;
            default:                                reg_reads = 2'd0;
        endcase
    end

    assign rs_used = (reg_reads != 2'd0);
    assign rt_used = (reg_reads == 2'd2);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight destinations, raises stall.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W    = 3,
    parameter int NUM_REGS = 8,
    parameter int DEPTH    = 3,
    parameter int FWD_EN   = 0,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [15:0]         instr,
    input  logic                dst_valid,
    input  logic [REG_W-1:0]    dst_reg,
    input  logic                dst_is_load,
    input  logic                flush,
    output logic                stall,
    output logic [1:0]          reg_reads,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [CNT_W-1:0]    stall_cnt
);

    sb_entry_t [DEPTH-1:0] ent;
    logic                  rs_used, rt_used, hit;
    logic [SB_REG_W-1:0]   rs, rt;

    reg_read_decode u_dec (
        .opcode    (instr[OPC_HI:OPC_LO]),
        .reg_reads (reg_reads),
        .rs_used   (rs_used),
        .rt_used   (rt_used)
    );

    assign rs = SB_REG_W'(instr[RS_HI:RS_LO]);
    assign rt = SB_REG_W'(instr[RT_HI:RT_LO]);

    // Source match against tracked entries; with forwarding only a load
    // one stage ahead cannot be bypassed in time
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (ent[k].v && ((rs_used && ent[k].rd == rs) || (rt_used && ent[k].rd == rt))) begin
                if (FWD_EN == 0)
                    hit = 1'b1;
                else if (k == 0 && ent[k].ld)
                    hit = 1'b1;
            end
        end
    end

    assign stall = issue_valid & ~flush & hit;

    // Destination shift register; a stalled instruction enters as a bubble
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ent <= '0;
        end else begin
            for (int k = DEPTH-1; k > 0; k--)
                ent[k] <= ent[k-1];
            if (stall)
                ent[0] <= '0;
            else
                ent[0] <= '{v: issue_valid & dst_valid, rd: SB_REG_W'(dst_reg), ld: dst_is_load};
        end
    end

    // One-hot OR of all valid destinations
    always_comb begin
        busy_mask = '0;
        for (int k = 0; k < DEPTH; k++)
            if (ent[k].v)
                busy_mask[ent[k].rd[REG_W-1:0]] = 1'b1;
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: three configurations share stimulus;
// a queue-of-writers model is compared every cycle, plus literal spot checks.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst, issue_valid, dst_valid, dst_is_load, flush;
    logic [15:0] instr;
    logic [2:0]  dst_reg;

    logic        stall_o   [3];
    logic [1:0]  rr_o      [3];
    logic [7:0]  busy_o    [3];
    logic [15:0] cnt0, cnt1;
    logic [3:0]  cnt2;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    // dut0: no forwarding; dut1: forwarding; dut2: no forwarding, 4-bit counter
    hazard_scoreboard #(.REG_W(3), .NUM_REGS(8), .DEPTH(3), .FWD_EN(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .instr(instr),
        .dst_valid(dst_valid), .dst_reg(dst_reg), .dst_is_load(dst_is_load),
        .flush(flush), .stall(stall_o[0]), .reg_reads(rr_o[0]),
        .busy_mask(busy_o[0]), .stall_cnt(cnt0));
    hazard_scoreboard #(.REG_W(3), .NUM_REGS(8), .DEPTH(3), .FWD_EN(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .instr(instr),
        .dst_valid(dst_valid), .dst_reg(dst_reg), .dst_is_load(dst_is_load),
        .flush(flush), .stall(stall_o[1]), .reg_reads(rr_o[1]),
        .busy_mask(busy_o[1]), .stall_cnt(cnt1));
    hazard_scoreboard #(.REG_W(3), .NUM_REGS(8), .DEPTH(3), .FWD_EN(0), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .instr(instr),
        .dst_valid(dst_valid), .dst_reg(dst_reg), .dst_is_load(dst_is_load),
        .flush(flush), .stall(stall_o[2]), .reg_reads(rr_o[2]),
        .busy_mask(busy_o[2]), .stall_cnt(cnt2));

    // ---------------- model ----------------
    localparam int MD = 3;
    localparam int M_FWD  [3] = '{0, 1, 0};
    localparam int M_CMAX [3] = '{65535, 65535, 15};

    // writers[i][a]: writer issued a+1 cycles ago (a < MD still blocks a read)
    bit m_v  [3][MD];
    int m_r  [3][MD];
    bit m_ld [3][MD];
    int m_cnt[3];

    function automatic int reads_of(logic [15:0] ins);
        int op;
        op = int'(ins[15:11]);
        if (op inside {[8:15], [20:23], 17, 18, 5, 7, 25}) return 1;
        if (op inside {16, 19, 26, 27, [28:31]})            return 2;
        return 0;
    endfunction

    function automatic bit m_stall(int i);
        int n, rs, rt;
        bit s;
        s  = 0;
        n  = reads_of(instr);
        rs = int'(instr[10:8]);
        rt = int'(instr[7:5]);
        if (!issue_valid || flush) return 0;
        for (int a = 0; a < MD; a++) begin
            if (m_v[i][a] && ((n >= 1 && m_r[i][a] == rs) || (n == 2 && m_r[i][a] == rt))) begin
                if (M_FWD[i] == 0 || (a == 0 && m_ld[i][a])) s = 1;
            end
        end
        return s;
    endfunction

    function automatic int m_busy(int i);
        int b;
        b = 0;
        for (int a = 0; a < MD; a++)
            if (m_v[i][a]) b = b | (1 << m_r[i][a]);
        return b;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit s;
            s = m_stall(i);
            if (rst || flush) begin
                for (int a = 0; a < MD; a++) m_v[i][a] = 0;
                if (rst) m_cnt[i] = 0;
            end else begin
                if (s && m_cnt[i] < M_CMAX[i]) m_cnt[i]++;
                for (int a = MD-1; a > 0; a--) begin
                    m_v[i][a]  = m_v[i][a-1];
                    m_r[i][a]  = m_r[i][a-1];
                    m_ld[i][a] = m_ld[i][a-1];
                end
                m_v[i][0]  = !s && issue_valid && dst_valid;
                m_r[i][0]  = int'(dst_reg);
                m_ld[i][0] = dst_is_load;
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            int cnts [3];
            cnts[0] = int'(cnt0); cnts[1] = int'(cnt1); cnts[2] = int'(cnt2);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("cmp_stall[%0d]", i), int'(stall_o[i]), int'(m_stall(i)));
                chk($sformatf("cmp_reads[%0d]", i), int'(rr_o[i]), reads_of(instr));
                chk($sformatf("cmp_busy[%0d]", i),  int'(busy_o[i]), m_busy(i));
                chk($sformatf("cmp_cnt[%0d]", i),   cnts[i], m_cnt[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drv(bit iv, logic [15:0] ins, bit dv, logic [2:0] dr, bit ld);
        issue_valid = iv; instr = ins; dst_valid = dv; dst_reg = dr; dst_is_load = ld;
    endtask

    task automatic idle(int n);
        drv(0, 16'h0800, 0, 3'd0, 0);
        repeat (n) step();
    endtask

    initial begin
        rst = 1; flush = 0;
        drv(0, 16'h0800, 0, 3'd0, 0);
        step(); step();
        chk_en = 1;
        @(negedge clk);
        chk("rst_stall", int'(stall_o[0]), 0);
        chk("rst_busy",  int'(busy_o[0]), 0);
        chk("rst_cnt",   int'(cnt0), 0);
        step(); rst = 0;

        // ADDI r1 then ADD r2,r1,r3
        drv(1, {5'b01000, 3'd6, 3'd1, 5'd0}, 1, 3'd1, 0);
        @(negedge clk); chk("t1_addi_reads", int'(rr_o[0]), 1);
        step();
        drv(1, {5'b11011, 3'd1, 3'd3, 3'd2, 2'b00}, 1, 3'd2, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t1_stall_nofwd", int'(stall_o[0]), (c < 3) ? 1 : 0);
            chk("t1_stall_fwd",   int'(stall_o[1]), 0);
            step();
        end
        idle(3);
        @(negedge clk); chk("t1_cnt", int'(cnt0), 3);

        // LD r4 then ST using r4 as the second source
        drv(1, {5'b10001, 3'd6, 3'd4, 5'd0}, 1, 3'd4, 1);
        step();
        drv(1, {5'b10000, 3'd6, 3'd4, 5'd0}, 0, 3'd0, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t2_ld_stall_fwd",   int'(stall_o[1]), (c == 0) ? 1 : 0);
            chk("t2_ld_stall_nofwd", int'(stall_o[0]), (c < 3) ? 1 : 0);
            step();
        end
        idle(3);
        @(negedge clk); chk("t2_cnt_fwd", int'(cnt1), 1);
        // ADDI r4 then ADD using r4: forwarded, no stall
        drv(1, {5'b01000, 3'd6, 3'd4, 5'd1}, 1, 3'd4, 0);
        step();
        drv(1, {5'b11011, 3'd4, 3'd6, 3'd2, 2'b00}, 1, 3'd2, 0);
        @(negedge clk);
        chk("t2_alu_fwd",   int'(stall_o[1]), 0);
        chk("t2_alu_nofwd", int'(stall_o[0]), 1);
        step();
        idle(4);

        // Write r0, then zero-read LBI and J
        drv(1, {5'b01000, 3'd6, 3'd0, 5'd0}, 1, 3'd0, 0);
        step();
        drv(1, {5'b11000, 3'd0, 8'h55}, 0, 3'd0, 0);
        @(negedge clk);
        chk("t3_lbi_reads", int'(rr_o[0]), 0);
        chk("t3_lbi_stall", int'(stall_o[0]), 0);
        step();
        drv(1, {5'b00100, 11'd0}, 0, 3'd0, 0);
        @(negedge clk);
        chk("t3_busy_r0", int'(busy_o[0]), 8'h01);
        chk("t3_j_stall", int'(stall_o[0]), 0);
        step();
        idle(3);

        // Flush while stalled on r5
        drv(1, {5'b01000, 3'd6, 3'd5, 5'd0}, 1, 3'd5, 0);
        step();
        drv(1, {5'b01100, 3'd5, 8'd0}, 0, 3'd0, 0);
        @(negedge clk); chk("t4_pre_stall", int'(stall_o[0]), 1);
        step();
        flush = 1;
        @(negedge clk);
        chk("t4_flush_stall", int'(stall_o[0]), 0);
        chk("t4_flush_busy",  int'(busy_o[0]), 8'h20);
        step();
        flush = 0;
        @(negedge clk);
        chk("t4_post_busy",  int'(busy_o[0]), 0);
        chk("t4_post_stall", int'(stall_o[0]), 0);
        step();
        idle(3);

        // Reset mid-stall with two valid entries
        drv(1, {5'b01000, 3'd6, 3'd1, 5'd0}, 1, 3'd1, 0);
        step();
        drv(1, {5'b01000, 3'd6, 3'd2, 5'd0}, 1, 3'd2, 0);
        step();
        drv(1, {5'b11011, 3'd1, 3'd2, 3'd3, 2'b00}, 1, 3'd3, 0);
        @(negedge clk); chk("t5_pre_stall", int'(stall_o[0]), 1);
        step();
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        chk("t5_stall", int'(stall_o[0]), 0);
        chk("t5_busy",  int'(busy_o[0]), 0);
        chk("t5_cnt",   int'(cnt0), 0);
        chk("t5_cnt4",  int'(cnt2), 0);
        step();
        idle(3);

        // Self-dependent ADDI r6,r6 held: 3 stalls per issue, 21 in 28 cycles
        drv(1, {5'b01000, 3'd6, 3'd6, 5'd1}, 1, 3'd6, 0);
        repeat (28) step();
        idle(1);
        @(negedge clk);
        chk("t6_sat4",   int'(cnt2), 15);
        chk("t6_cnt16",  int'(cnt0), 21);
        idle(2);
        @(negedge clk);
        chk("t6_sat4_hold", int'(cnt2), 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
